// File: rtl/universal_shift_register_pkg.sv
// Shared mode encodings and the mode type for the universal shift register.
package usr_pkg;

  typedef logic [2:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 3'b000;
  localparam usr_mode_t MODE_SHR  = 3'b001;
  localparam usr_mode_t MODE_SHL  = 3'b010;
  localparam usr_mode_t MODE_LOAD = 3'b011;
  localparam usr_mode_t MODE_ROR  = 3'b100;
  localparam usr_mode_t MODE_ROL  = 3'b101;
  localparam usr_mode_t MODE_ASR  = 3'b110;
  localparam usr_mode_t MODE_CLR  = 3'b111;

endpackage

// File: rtl/universal_shift_register_if.sv
// Control, data and serial signals of the universal shift register.
interface universal_shift_register_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;

  modport master (
    output en, mode, d, sin_r, sin_l,
    input  q, sout_r, sout_l
  );

  modport slave (
    input  en, mode, d, sin_r, sin_l,
    output q, sout_r, sout_l
  );
endinterface

// File: rtl/universal_shift_register_bit_cell.sv
// One register bit: 8:1 next-state mux plus flop. The rotate inputs exist
// only when USR_ROTATE_EN is defined; otherwise ROR/ROL behave as hold.
module usr_bit_cell
  import usr_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  usr_mode_t mode,
  input  logic      d_bit,
  input  logic      shr_in,
  input  logic      shl_in,
  input  logic      asr_in,
`ifdef USR_ROTATE_EN
  input  logic      ror_in,
  input  logic      rol_in,
`endif
  output logic      q
);

  logic q_next;

  always_comb begin
    q_next = q;
    case (mode)
      MODE_SHR:  q_next = shr_in;
      MODE_SHL:  q_next = shl_in;
      MODE_LOAD: q_next = d_bit;
`ifdef USR_ROTATE_EN
      MODE_ROR:  q_next = ror_in;
      MODE_ROL:  q_next = rol_in;
`endif
      MODE_ASR:  q_next = asr_in;
      MODE_CLR:  q_next = RST_BIT;
      default:   q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_BIT;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register built from per-bit cells.
// Optional rotate modes (100/101) are enabled by defining USR_ROTATE_EN.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                        clk,
  input logic                        rst,
  universal_shift_register_if.slave  bus
);

  logic [WIDTH-1:0] q_int;

  assign bus.q      = q_int;
  assign bus.sout_r = q_int[0];
  assign bus.sout_l = q_int[WIDTH-1];

  // Edge cells take serial inputs for shifts, their own bit for ASR sign
  // extension and the opposite end of the register for rotates.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic shr_in;
    logic shl_in;
    logic asr_in;
`ifdef USR_ROTATE_EN
    logic ror_in;
    logic rol_in;
`endif

    if (i == WIDTH - 1) begin : g_msb
      assign shr_in = bus.sin_r;
      assign asr_in = q_int[WIDTH-1];
`ifdef USR_ROTATE_EN
      assign ror_in = q_int[0];
`endif
    end else begin : g_upper
      assign shr_in = q_int[i+1];
      assign asr_in = q_int[i+1];
`ifdef USR_ROTATE_EN
      assign ror_in = q_int[i+1];
`endif
    end

    if (i == 0) begin : g_lsb
      assign shl_in = bus.sin_l;
`ifdef USR_ROTATE_EN
      assign rol_in = q_int[WIDTH-1];
`endif
    end else begin : g_lower
      assign shl_in = q_int[i-1];
`ifdef USR_ROTATE_EN
      assign rol_in = q_int[i-1];
`endif
    end

    usr_bit_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.en),
      .mode   (bus.mode),
      .d_bit  (bus.d[i]),
      .shr_in (shr_in),
      .shl_in (shl_in),
      .asr_in (asr_in),
`ifdef USR_ROTATE_EN
      .ror_in (ror_in),
      .rol_in (rol_in),
`endif
      .q      (q_int[i])
    );
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8, RST_VAL=0); expected
// rotate results follow whether USR_ROTATE_EN is defined.
module tb_universal_shift_register;
  import usr_pkg::*;

`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] exp_q;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   assertion_count = 0;
  int   failure_count   = 0;
  vec_t vecs[$];

  universal_shift_register_if #(.WIDTH(8)) bus ();

  universal_shift_register #(
    .WIDTH   (8),
    .RST_VAL (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    assertion_count++;
    if (actual !== expected) begin
      failure_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    @(negedge clk);
    rst      = v.rst;
    bus.en   = v.en;
    bus.mode = v.mode;
    bus.d    = v.d;
    bus.sin_r = v.sin_r;
    bus.sin_l = v.sin_l;
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    driveInputs(v);
    @(posedge clk);
    #1;
    checkOutput({name, " q"}, bus.q, v.exp_q);
    checkOutput({name, " sout_r"}, {7'd0, bus.sout_r}, {7'd0, v.exp_q[0]});
    checkOutput({name, " sout_l"}, {7'd0, bus.sout_l}, {7'd0, v.exp_q[7]});
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m,
                              input logic [7:0] dd, input logic sr, input logic sl,
                              input logic [7:0] eq);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.d = dd;
    v.sin_r = sr; v.sin_l = sl; v.exp_q = eq;
    return v;
  endfunction

  initial begin
    logic [7:0] fill_bits;
    logic [7:0] exp_val;
    vec_t       v;

    rst = 1'b1; bus.en = 1'b0; bus.mode = MODE_HOLD; bus.d = 8'h00;
    bus.sin_r = 1'b0; bus.sin_l = 1'b0;

    // Sequential table: each row's expectation depends on the previous rows.
    vecs.push_back(mk(1, 1, MODE_LOAD, 8'hA5, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'hA5, 0, 0, 8'hA5));
    vecs.push_back(mk(1, 1, MODE_LOAD, 8'hFF, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'hA5, 0, 0, 8'hA5));
    vecs.push_back(mk(1, 0, MODE_HOLD, 8'h00, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h3C, 0, 0, 8'h3C));
    vecs.push_back(mk(0, 1, MODE_HOLD, 8'hFF, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 1, MODE_HOLD, 8'h00, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 1, MODE_HOLD, 8'h00, 0, 0, 8'h3C));
    vecs.push_back(mk(0, 0, MODE_LOAD, 8'hFF, 0, 0, 8'h3C));
    vecs.push_back(mk(0, 0, MODE_SHR,  8'h00, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81));
    vecs.push_back(mk(0, 1, MODE_SHR,  8'h00, 1, 0, 8'hC0));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81));
    vecs.push_back(mk(0, 1, MODE_SHL,  8'h00, 1, 0, 8'h02));
    vecs.push_back(mk(0, 1, MODE_SHL,  8'h00, 0, 1, 8'h05));
    vecs.push_back(mk(0, 1, MODE_SHR,  8'h00, 0, 1, 8'h02));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h90, 0, 0, 8'h90));
    vecs.push_back(mk(0, 1, MODE_ASR,  8'h00, 0, 0, 8'hC8));
    vecs.push_back(mk(0, 1, MODE_ASR,  8'h00, 0, 1, 8'hE4));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h40, 0, 0, 8'h40));
    vecs.push_back(mk(0, 1, MODE_ASR,  8'h00, 1, 0, 8'h20));
    vecs.push_back(mk(0, 1, MODE_CLR,  8'hFF, 1, 1, 8'h00));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81));
    vecs.push_back(mk(0, 1, MODE_ROR,  8'h00, 0, 1, ROT ? 8'hC0 : 8'h81));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81));
    vecs.push_back(mk(0, 1, MODE_ROL,  8'h00, 0, 0, ROT ? 8'h03 : 8'h81));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h5A, 0, 0, 8'h5A));
    vecs.push_back(mk(0, 0, MODE_CLR,  8'h00, 0, 0, 8'h5A));
    vecs.push_back(mk(0, 1, MODE_LOAD, 8'h80, 0, 0, 8'h80));
    vecs.push_back(mk(0, 1, MODE_SHL,  8'h00, 0, 1, 8'h01));
    vecs.push_back(mk(0, 1, MODE_SHR,  8'h00, 0, 1, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Outgoing bits are visible before the shifting edge.
    applyStimulus(mk(0, 1, MODE_LOAD, 8'h81, 0, 0, 8'h81), "preload81");
    driveInputs(mk(0, 1, MODE_SHR, 8'h00, 1, 0, 8'h00));
    #1;
    checkOutput("sout_r before SHR", {7'd0, bus.sout_r}, 8'h01);
    checkOutput("sout_l before SHR", {7'd0, bus.sout_l}, 8'h01);
    @(posedge clk);
    #1;
    checkOutput("SHR from 81", bus.q, 8'hC0);

    // Serial fill: the first bit in ends up at the LSB.
    applyStimulus(mk(0, 1, MODE_CLR, 8'h00, 0, 0, 8'h00), "fill clear");
    fill_bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      driveInputs(mk(0, 1, MODE_SHR, 8'h00, fill_bits[i], ~fill_bits[i], 8'h00));
      @(posedge clk);
    end
    #1;
    checkOutput("serial fill", bus.q, 8'h4D);

    // Repeated ASR from 0x80 smears the sign bit across the register.
    applyStimulus(mk(0, 1, MODE_LOAD, 8'h80, 0, 0, 8'h80), "asr preload");
    exp_val = 8'h80;
    for (int i = 0; i < 7; i++) begin
      exp_val = {exp_val[7], exp_val[7:1]};
      applyStimulus(mk(0, 1, MODE_ASR, 8'h00, 0, 0, exp_val), $sformatf("asr%0d", i));
    end
    checkOutput("asr saturate", bus.q, 8'hFF);

    // Eight rotates return the starting value (hold build leaves it unchanged).
    applyStimulus(mk(0, 1, MODE_LOAD, 8'h4D, 0, 0, 8'h4D), "ror preload");
    v = mk(0, 1, MODE_ROR, 8'h00, 1, 1, ROT ? 8'hA6 : 8'h4D);
    applyStimulus(v, "ror first");
    for (int i = 1; i < 8; i++) begin
      driveInputs(mk(0, 1, MODE_ROR, 8'h00, 1, 1, 8'h00));
      @(posedge clk);
    end
    #1;
    checkOutput("ror x8", bus.q, 8'h4D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertion_count, failure_count);
    $finish;
  end

endmodule
